mem_access_master: RTL and testbench
====================================

Name: mem_access_master

Overview:
- Initiator-side controller that drives the single-port synchronous data memory (clk, addr, dataIn, dataOut, cs, we) on behalf of the CPU load/store stage.
- Accepts byte-addressed load/store requests of byte, halfword or word size.
- Checks alignment and range, then performs the access; sub-word stores are done as read-modify-write.
- Returns data, sign- or zero-extended, with a one-cycle response pulse. Big-endian byte lanes (MIPS).

Parameters:
- ADDR_W, 10: word-address width of the attached memory, so byte space is 2^(ADDR_W+2).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when valid&ready at rising edge
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (error)
- req_signed  in  1  load sign-extend enable
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for sub-word
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load result (0 for stores and errors)
- rsp_err  out  1  misaligned, out-of-range or illegal size
- mem_cs  out  1  memory chip select
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after a cs=1, we=0 cycle

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low, rst_n.
- Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_cs=0; mem_we=0; mem_addr=0; mem_wdata=0.
- Output timing: mem_cs and mem_we are decoded combinationally from the state. Asserting rst_n low mid-access therefore drops cs/we immediately, and no write occurs.
- Acceptance: req_ready=1 only in IDLE. Accepting a request captures the word address req_addr[ADDR_W+1:2], byte offset, size, sign and wdata.
- Error checks:
  - out-of-range: req_addr[31:ADDR_W+2] != 0
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0
  - req_size=11
- Lanes: byte offset 0 = bits 31:24; half offset 0 = bits 31:16, half offset 2 = bits 15:0.
- States:
  - IDLE: on accept, go to ERR if any check fails; else RD for a load or sub-word store; else WR for a word store.
  - RD: mem_cs=1, mem_we=0. Go to RDD.
  - RDD: mem_rdata valid.
    - Load: register the extracted lane into rsp_rdata, sign-extended if req_signed else zero-extended. Go to RESP.
    - Sub-word store: merge the req_wdata low byte/half into the addressed lane of mem_rdata, register into mem_wdata. Go to WR.
  - WR: mem_cs=1, mem_we=1, with mem_addr and mem_wdata stable. Go to RESP.
  - ERR: no memory access. rsp_rdata=0, rsp_err=1. Go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle. Go to IDLE. There is no response backpressure.
- Latency, counted from the accepting edge to the edge on which rsp_valid is first sampled high:
  - load: 3 cycles
  - word store: 2 cycles
  - sub-word store: 4 cycles
  - error: 2 cycles
- Hold rules: mem_addr and mem_wdata hold their last values outside an access. rsp_err is cleared when the next request is accepted.
- Accept edge: req_valid is ignored outside IDLE. A request whose valid drops before an accept edge is never seen.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - the state enum IDLE/RD/RDD/WR/ERR/RESP
  - the lane-select constants
- One combinational sub-module, mem_lane_align: load extract/extend and store merge from offset, size and signed.

Test Plan:
1. Word store 999 to addr 0x10, then word load at 0x10 -> memory word 4 = 0x000003E7; rsp_rdata=0x000003E7, rsp_err=0, rsp_valid 3 cycles after accept.
2. Byte store 0xAB to 0x11 after scenario 1 -> RD, RDD, WR sequence; word 4 becomes 0x00AB03E7. Signed byte load at 0x11 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
3. Signed half load at 0x12 -> 0x000003E7. Half store 0x8001 to 0x10, then signed half load at 0x10 -> 0xFFFF8001; word 4 = 0x800103E7.
4. Errors: word load at 0x13, half store at 0x11, load at 0x1000 (ADDR_W=10) and req_size=11 -> rsp_err=1, rsp_rdata=0, mem_cs never asserted, rsp_valid 2 cycles after accept, memory unchanged.
5. rst_n low during WR of a byte store -> mem_cs and mem_we drop in the same cycle; word unchanged; after release all outputs are at reset values and req_ready=1.
6. Back-to-back: req_valid held high with 5 queued loads -> each accepted only in IDLE; responses in order, one per 4 cycles, no lost or duplicated rsp_valid.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access master.
package mem_access_pkg;

  // Request size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Right-justified lane masks; shifted into place by lane_shift()
  localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [31:0] HALF_MASK = 32'h0000_ffff;
  localparam logic [31:0] WORD_MASK = 32'hffff_ffff;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDD,
    WR,
    ERR,
    RESP
  } state_e;

  // Big-endian lane position: byte offset 0 and half offset 0 live in the top bits.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] offset);
    logic [4:0] sh;
    unique case (size)
      SZ_BYTE: sh = {~offset, 3'b000};
      SZ_HALF: sh = {~offset[1], 4'b0000};
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  shift;
  logic [31:0] mask;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Select the addressed lane, extend it for loads and splice it in for stores
  always_comb begin
    shift  = lane_shift(size_i, offset_i);
    lane_b = rdata_i[shift +: 8];
    lane_h = rdata_i[shift +: 16];
    load_o = rdata_i;
    mask   = WORD_MASK;
    unique case (size_i)
      SZ_BYTE: begin
        load_o = {{24{signed_i & lane_b[7]}}, lane_b};
        mask   = BYTE_MASK << shift;
      end
      SZ_HALF: begin
        load_o = {{16{signed_i & lane_h[15]}}, lane_h};
        mask   = HALF_MASK << shift;
      end
      default: begin
        load_o = rdata_i;
        mask   = WORD_MASK;
      end
    endcase
    merge_o = (rdata_i & ~mask) | ((wdata_i << shift) & mask);
  end

endmodule

// File: rtl/mem_access_master.sv
// Load/store initiator for a single-port synchronous data memory.
// Sub-word stores are read-modify-write; errors never touch the memory.
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       req_wdata_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic              we_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  // Request legality: range, alignment and size encoding
  always_comb begin
    req_err = (|req_addr[31:ADDR_W+2])
            || (req_size == SZ_HALF && req_addr[0])
            || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            || (req_size == SZ_ILL);
  end

  mem_lane_align u_align (
    .offset_i (off_q),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .rdata_i  (mem_rdata),
    .wdata_i  (req_wdata_q),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  // Access sequencer with registered response and memory-side data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_wdata_q <= '0;
      off_q       <= '0;
      size_q      <= SZ_BYTE;
      sgn_q       <= 1'b0;
      we_q        <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            off_q       <= req_addr[1:0];
            size_q      <= req_size;
            sgn_q       <= req_signed;
            we_q        <= req_we;
            req_wdata_q <= req_wdata;
            if (req_err) begin
              state_q <= ERR;
            end else begin
              // Memory-side address only moves for real accesses
              mem_addr_q <= req_addr[ADDR_W+1:2];
              if (req_we && req_size == SZ_WORD) begin
                mem_wdata_q <= req_wdata;
                state_q     <= WR;
              end else begin
                state_q <= RD;
              end
            end
          end
        end
        RD:  state_q <= RDD;
        RDD: begin
          if (we_q) begin
            mem_wdata_q <= merge_data;
            state_q     <= WR;
          end else begin
            rsp_rdata_q <= load_data;
            state_q     <= RESP;
          end
        end
        WR:  state_q <= RESP;
        ERR: begin
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
          state_q     <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // State-decoded strobes so an asynchronous reset kills cs/we at once
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    mem_cs    = (state_q == RD) || (state_q == WR);
    mem_we    = (state_q == WR);
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a behavioural synchronous RAM.
module tb_mem_access_master;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int total = 0;
  int bad   = 0;
  int cs_cnt = 0;
  int rsp_cnt = 0;

  mem_access_master #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM: read data appears the cycle after cs & !we
  always @(posedge clk) begin
    if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_cs && !mem_we) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) if (mem_cs) cs_cnt <= cs_cnt + 1;
  always @(negedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, return response data/err and accept-to-response latency
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99; rd = '0; er = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
  endtask

  task automatic run_chk(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(we, sz, sg, addr, wd, rd, er, lat);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_rdata"}, rd, exp_rd);
    check_eq({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    @(negedge clk);
    check_eq({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  logic [1:0]  bb_sz [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
  logic        bb_sg [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] bb_ad [5] = '{32'h10, 32'h10, 32'h10, 32'h12, 32'h13};
  logic [31:0] bb_ex [5] = '{32'h8001_03e7, 32'h0000_0080, 32'hffff_ff80,
                             32'h0000_03e7, 32'h0000_00e7};

  initial begin
    int          cs_before;
    int          rsp_before;
    int          n;
    int          got_lat;
    longint      t_prev;
    longint      t_acc;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_cs_we", {30'd0, mem_cs, mem_we}, 32'd0);
    check_eq("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);

    // Word store / load
    run_chk("s1_sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'd999, 32'd0, 1'b0, 2);
    check_eq("s1_mem4", mem[4], 32'h0000_03e7);
    run_chk("s1_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h0000_03e7, 1'b0, 3);

    // Byte store via read-modify-write, then byte loads
    run_chk("s2_sb", 1'b1, 2'b00, 1'b0, 32'h11, 32'hffff_ffab, 32'd0, 1'b0, 4);
    check_eq("s2_mem4", mem[4], 32'h00ab_03e7);
    run_chk("s2_lb", 1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 32'hffff_ffab, 1'b0, 3);
    run_chk("s2_lbu", 1'b0, 2'b00, 1'b0, 32'h11, 32'd0, 32'h0000_00ab, 1'b0, 3);

    // Halfword lanes
    run_chk("s3_lh12", 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 32'h0000_03e7, 1'b0, 3);
    run_chk("s3_sh", 1'b1, 2'b01, 1'b0, 32'h10, 32'h1234_8001, 32'd0, 1'b0, 4);
    check_eq("s3_mem4", mem[4], 32'h8001_03e7);
    run_chk("s3_lh10", 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 32'hffff_8001, 1'b0, 3);

    // Errors: no memory cycle, fixed latency
    cs_before = cs_cnt;
    run_chk("s4_lw_mis", 1'b0, 2'b10, 1'b0, 32'h13, 32'd0, 32'd0, 1'b1, 2);
    run_chk("s4_sh_mis", 1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 32'd0, 1'b1, 2);
    run_chk("s4_oor", 1'b0, 2'b10, 1'b0, 32'h1000, 32'd0, 32'd0, 1'b1, 2);
    run_chk("s4_badsz", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1, 2);
    check_eq("s4_no_cs", cs_cnt - cs_before, 32'd0);
    check_eq("s4_mem4", mem[4], 32'h8001_03e7);
    // A good request clears the sticky error
    run_chk("s4_clr", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'h0000_0080, 1'b0, 3);

    // Reset in the write cycle of a byte store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h10;
    req_wdata = 32'h55; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("s5_wr_cswe", {30'd0, mem_cs, mem_we}, 32'd3);
    rst_n = 1'b0;
    #1;
    check_eq("s5_rst_cswe", {30'd0, mem_cs, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("s5_mem4", mem[4], 32'h8001_03e7);
    check_eq("s5_ready", {31'd0, req_ready}, 32'd1);
    check_eq("s5_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check_eq("s5_rdata", rsp_rdata, 32'd0);
    check_eq("s5_mem_addr", {22'd0, mem_addr}, 32'd0);
    check_eq("s5_mem_wdata", mem_wdata, 32'd0);

    // Back-to-back loads with valid held high
    rsp_before = rsp_cnt;
    t_prev = 0;
    @(negedge clk);
    req_we = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_size = bb_sz[i]; req_signed = bb_sg[i]; req_addr = bb_ad[i];
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      t_acc = $time;
      if (i > 0) check_eq($sformatf("s6_period%0d", i), 32'(t_acc - t_prev), 32'd40);
      t_prev = t_acc;
      got_lat = 99;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (rsp_valid) begin got_lat = k; break; end
      end
      if (i == 4) req_valid = 1'b0;
      check_eq($sformatf("s6_lat%0d", i), got_lat, 32'd3);
      check_eq($sformatf("s6_rdata%0d", i), rsp_rdata, bb_ex[i]);
    end
    repeat (3) @(negedge clk);
    check_eq("s6_rsp_count", rsp_cnt - rsp_before, 32'd5);
    check_eq("s6_idle", {31'd0, req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
